encoder_8_3_seq: RTL

Registered 8-to-3 priority encoder with sticky request capture and a valid/ack handshake. It is the encode-side counterpart of the 3-to-8 decoder: it collapses eight one-hot request lines into a 3-bit index. It sits between request sources (interrupt or event lines) and a consumer that services one index at a time and acknowledges it. Bit 7 has the highest priority.

---
 rtl/encoder_pkg.sv | 24 ++
 rtl/encoder_8_3_seq_prio_pick.sv | 29 ++
 rtl/encoder_8_3_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg
// Shared constants, FSM state type and a one-hot helper for the registered
// 8-to-3 priority encoder (encoder_8_3_seq) and its picker (prio_pick).
package encoder_pkg;

  localparam int ENC_N  = 8;
  localparam int ENC_AW = 3;

  // IDLE: nothing presented, waiting for a pending request.
  // PRESENT: an index is held on the outputs until acked or disabled.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  // Expand an index into a one-hot mask of ENC_N bits.
  function automatic logic [ENC_N-1:0] onehot(input logic [ENC_AW-1:0] idx);
    logic [ENC_N-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/encoder_8_3_seq_prio_pick.sv
// prio_pick
// Purely combinational priority picker: reports the index of the highest set
// bit of the input vector and whether any bit is set at all.
// Ports:
//   vec_i  in  N  : vector to search
//   idx_o  out AW : index of the highest set bit (0 when vec_i is zero)
//   any_o  out 1  : vec_i is non-zero
module prio_pick #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic [N-1:0]  vec_i,
  output logic [AW-1:0] idx_o,
  output logic          any_o
);

  // Scan upward so that a higher set bit overwrites a lower one, leaving the
  // highest-priority index once the loop is done.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        idx_o = AW'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_8_3_seq.sv
// encoder_8_3_seq
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ack handshake. Requests are latched into a pending register; the
// highest pending bit is presented as an index until the consumer acks it.
// Ports:
//   clk_i   in  1  : clock, rising edge
//   rst_ni  in  1  : asynchronous active-low reset
//   e_i     in  1  : enable; when low, nothing is captured or presented
//   d_i     in  N  : request lines, level-sampled every edge
//   ack_i   in  1  : consumer accepts the presented index
//   a_o     out AW : presented index (registered)
//   v_o     out 1  : a_o is valid (registered)
//   p_o     out N  : pending-request register
module encoder_8_3_seq
  import encoder_pkg::*;
#(
  parameter int N  = ENC_N,
  parameter int AW = ENC_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          e_i,
  input  logic [N-1:0]  d_i,
  input  logic          ack_i,
  output logic [AW-1:0] a_o,
  output logic          v_o,
  output logic [N-1:0]  p_o
);

  enc_state_t    state_q;
  logic [N-1:0]  p_q, p_d;
  logic [AW-1:0] a_q;
  logic          v_q;
  logic [N-1:0]  clrMask;
  logic [AW-1:0] pickIdx;
  logic          pickAny;

  // The picker always looks at the registered pending bits, never raw d_i,
  // so a new request takes one extra edge before it can be presented.
  prio_pick #(
    .N  (N),
    .AW (AW)
  ) u_pick (
    .vec_i (p_q),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );

  // A presented bit is only retired on an ack while enabled; an ack arriving
  // together with a disable is dropped so the request survives. New requests
  // are OR-ed in after the clear, so a request still held high on the ack
  // edge keeps its pending bit.
  always_comb begin
    clrMask = '0;
    if (v_q && ack_i && e_i) begin
      clrMask = onehot(a_q);
    end
    p_d = p_q;
    if (e_i) begin
      p_d = (p_q & ~clrMask) | d_i;
    end
  end

  // Pending register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  // Presentation FSM. Once an index is presented it is held unchanged until
  // it is acked or enable drops; a higher-priority arrival never preempts it.
  // Leaving PRESENT always passes through IDLE, which guarantees a cycle with
  // v_o low between two presentations.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (e_i && pickAny) begin
            a_q     <= pickIdx;
            v_q     <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (!e_i || ack_i) begin
            v_q     <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          v_q     <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a_o = a_q;
  assign v_o = v_q;
  assign p_o = p_q;

endmodule
